// File: rtl/mul_seq_if.sv
// -----------------------------------------------------------------------------
// mul_seq_if : signal bundle between the M-unit issue logic, the mul_seq
//              sequencer and the shared 10x10 chunk multiplier.
//
// Request side   : req_valid/req_ready handshake, funct, rs1, rs2, flush
// Response side  : resp_valid/resp_ready handshake, result
// Chunk datapath : mul_en, mul_a, mul_b (from sequencer), mul_p (to sequencer,
//                  combinational unsigned mul_a*mul_b)
//
// Modports:
//   master : the environment around the sequencer (issue logic, consumer and
//            chunk multiplier)
//   slave  : the mul_seq sequencer itself
// -----------------------------------------------------------------------------
interface mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  funct;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        mul_en;
  logic [9:0]  mul_a;
  logic [9:0]  mul_b;
  logic [19:0] mul_p;

  modport master (
    output req_valid, funct, rs1, rs2, flush, resp_ready, mul_p,
    input  req_ready, resp_valid, result, mul_en, mul_a, mul_b
  );

  modport slave (
    input  req_valid, funct, rs1, rs2, flush, resp_ready, mul_p,
    output req_ready, resp_valid, result, mul_en, mul_a, mul_b
  );
endinterface

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq : multi-cycle sequencer for RV32M MUL / MULH / MULHSU / MULHU.
//
// Accepts a 32x32 request, stores operand magnitudes, drives a shared unsigned
// 10x10 chunk multiplier for 16 cycles (every chunk pair of A and B), sums the
// shifted partial products into a 64-bit magnitude, then applies the sign and
// selects the upper or lower product word.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   m_if  : mul_seq_if.slave (request, response and chunk multiplier signals)
//
// funct : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
// -----------------------------------------------------------------------------
module mul_seq (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  m_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic        upper_q, upper_d;
  logic [31:0] result_q, result_d;

  // Chunk k of a 32-bit magnitude; the top chunk carries only bits [31:30].
  function automatic logic [9:0] chunk(input logic [31:0] x, input logic [1:0] k);
    logic [9:0] c;
    case (k)
      2'd0:    c = x[9:0];
      2'd1:    c = x[19:10];
      2'd2:    c = x[29:20];
      default: c = {8'b0, x[31:30]};
    endcase
    return c;
  endfunction

  // Operand signedness from funct. MUL is handled as unsigned because the low
  // product word does not depend on signedness.
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  assign s1   = (m_if.funct == 2'b01) || (m_if.funct == 2'b10);
  assign s2   = (m_if.funct == 2'b01);
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag1 = (s1 && m_if.rs1[31]) ? (~m_if.rs1 + 32'd1) : m_if.rs1;
  assign mag2 = (s2 && m_if.rs2[31]) ? (~m_if.rs2 + 32'd1) : m_if.rs2;

  // Partial product alignment: chunk i of A times chunk j of B weighs 2^(10(i+j)).
  logic [5:0]  shamt;
  logic [63:0] partial;
  assign shamt   = (6'(cnt_q[3:2]) + 6'(cnt_q[1:0])) * 6'd10;
  assign partial = {44'b0, m_if.mul_p} << shamt;

  logic [63:0] fixed;
  assign fixed = neg_q ? (~acc_q + 64'd1) : acc_q;

  // NOTE: every next-state variable gets its hold value before the case
  // statement, so no path through the block can leave one unassigned and
  // infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    upper_d  = upper_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        // flush in IDLE only blocks acceptance for that cycle
        if (m_if.req_valid && !m_if.flush) begin
          a_d     = mag1;
          b_d     = mag2;
          neg_d   = (s1 & m_if.rs1[31]) ^ (s2 & m_if.rs2[31]);
          upper_d = (m_if.funct != 2'b00);
          acc_d   = '0;
          cnt_d   = '0;
          // A zero operand gives a zero product; skip the chunk loop entirely.
          state_d = ((mag1 == '0) || (mag2 == '0)) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (m_if.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_q + partial;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (m_if.flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = upper_q ? fixed[63:32] : fixed[31:0];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_if.flush || m_if.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      upper_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      upper_q  <= upper_d;
      result_q <= result_d;
    end
  end

  assign m_if.req_ready  = (state_q == ST_IDLE);
  assign m_if.resp_valid = (state_q == ST_DONE);
  assign m_if.result     = result_q;
  assign m_if.mul_en     = (state_q == ST_CALC);
  assign m_if.mul_a      = m_if.mul_en ? chunk(a_q, cnt_q[3:2]) : '0;
  assign m_if.mul_b      = m_if.mul_en ? chunk(b_q, cnt_q[1:0]) : '0;

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq : self-checking bench for mul_seq. Directed vectors plus random
// requests checked against a plain 64-bit arithmetic reference model; the
// chunk multiplier is modelled combinationally.
// -----------------------------------------------------------------------------
module tb_mul_seq;
  logic clk;
  logic rst_n;
  mul_seq_if bus ();

  mul_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 10x10 unsigned chunk multiplier, combinational.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit product of sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic sa, sb;
    sa = (f == 2'b01) || (f == 2'b10);
    sb = (f == 2'b01);
    xa = sa ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one request, wait for its response, optionally stall the consumer,
  // and check result, latency and number of chunk-multiplier cycles.
  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    int edges;
    int en_cnt;
    int exp_lat;
    logic [31:0] held;
    exp_lat = ((a == 0) || (b == 0)) ? 2 : 18;
    check({tag, "_ready_before"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.funct     = f;
    bus.rs1       = a;
    bus.rs2       = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    edges  = 1;
    en_cnt = bus.mul_en ? 1 : 0;
    while (!bus.resp_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (bus.mul_en) en_cnt++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "_mul_en_cycles"}, 64'(en_cnt), (exp_lat == 18) ? 64'd16 : 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'(ref_mul(f, a, b)));
    held = bus.result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_stall_result"}, 64'(bus.result), 64'(held));
      check({tag, "_stall_req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, "_idle_after"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a, b;
    bus.req_valid  = 1'b0;
    bus.funct      = 2'b00;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_mul_en", 64'(bus.mul_en), 64'd0);
    check("reset_mul_ab", {44'b0, bus.mul_a, bus.mul_b}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, checked against fixed expected words as well.
    do_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mulhu_ff_const", 64'(bus.result), 64'h0FFFFFFFE);
    do_op("mul_1234", 2'b00, 32'h12345678, 32'h9ABCDEF0, 0);
    check("mul_1234_const", 64'(bus.result), 64'h242D2080);
    do_op("mulhu_1234", 2'b11, 32'h12345678, 32'h9ABCDEF0, 0);
    check("mulhu_1234_const", 64'(bus.result), 64'h0B00EA4E);
    do_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 0);
    check("mulh_min_const", 64'(bus.result), 64'h40000000);
    do_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'h00000002, 0);
    check("mulhsu_m1_const", 64'(bus.result), 64'hFFFFFFFF);
    do_op("mulh_m1", 2'b01, 32'hFFFFFFFF, 32'h00000002, 0);
    check("mulh_m1_const", 64'(bus.result), 64'hFFFFFFFF);
    do_op("mul_zero", 2'b00, 32'h00000000, 32'hDEADBEEF, 0);
    check("mul_zero_const", 64'(bus.result), 64'd0);

    // Flush in CALC at CNT=7: back to IDLE, no response ever.
    bus.req_valid = 1'b1;
    bus.funct     = 2'b00;
    bus.rs1       = 32'h01234567;
    bus.rs2       = 32'h0FEDCBA9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    check("flush_in_calc", 64'(bus.mul_en), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_idle", 64'(bus.req_ready), 64'd1);
    check("flush_mul_en", 64'(bus.mul_en), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
      end
      check("flush_no_resp", 64'(seen), 64'd0);
    end
    do_op("mul_3x5", 2'b00, 32'd3, 32'd5, 0);
    check("mul_3x5_const", 64'(bus.result), 64'd15);

    // Flush in IDLE blocks acceptance.
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    check("flush_idle_block", 64'(bus.req_ready), 64'd1);

    // Response stall for 10 cycles, then back-to-back request.
    do_op("stall", 2'b01, 32'hF0F0F0F0, 32'h12345678, 10);
    do_op("b2b", 2'b10, 32'h87654321, 32'h00ABCDEF, 0);

    // Random requests with occasional zero operands and consumer stalls.
    for (int n = 0; n < 40; n++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 4) == 0) a = {a[31], 31'b0};
      do_op($sformatf("rnd%0d", n), f, a, b, $urandom_range(0, 3));
    end

    // Asynchronous reset mid-operation.
    bus.req_valid = 1'b1;
    bus.funct     = 2'b11;
    bus.rs1       = 32'hCAFEBABE;
    bus.rs2       = 32'h13579BDF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 64'(bus.req_ready), 64'd1);
    check("arst_mul_en", 64'(bus.mul_en), 64'd0);
    check("arst_mul_a", 64'(bus.mul_a), 64'd0);
    check("arst_result", 64'(bus.result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
      end
      check("arst_no_resp", 64'(seen), 64'd0);
    end
    do_op("after_arst", 2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end
endmodule
